seq_trigger_monitor: RTL and testbench



---
 rtl/seq_mon_pkg.sv | 13 +
 rtl/seq_trigger_monitor_sat_counter.sv | 25 ++
 rtl/seq_trigger_monitor.sv | 97 +++++++++
 tb/tb_seq_trigger_monitor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mon_pkg.sv
// Shared types, limits and the GAP range check for the sequence trigger monitor.
package seq_mon_pkg;

  localparam int GAP_MAX    = 8;
  localparam int CNT_W_DFLT = 16;

  typedef logic [CNT_W_DFLT-1:0] cnt_t;

  function automatic bit gap_in_range(input int gap);
    return (gap >= 1) && (gap <= GAP_MAX);
  endfunction

endpackage

// File: rtl/seq_trigger_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (inc && (r_q != {WIDTH{1'b1}})) begin
      r_q <= r_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seq_trigger_monitor.sv
// Endpoint-based "a ##1 b |-> ##GAP c" monitor with per-attempt pass/fail pulses.
// Statistics counters are built only when SEQ_MON_STATS_EN is defined.
module seq_trigger_monitor
  import seq_mon_pkg::*;
#(
  parameter int GAP   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             endpoint,
  output logic             pass,
  output logic             fail,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  if (!gap_in_range(GAP)) begin : g_bad_gap
    $error("seq_trigger_monitor: GAP must be within 1..GAP_MAX");
  end

  logic           r_a_q;
  logic [GAP-1:0] r_pend;
  logic           r_endpoint;
  logic           r_pass;
  logic           r_fail;
  logic           r_busy;

  logic           w_endpoint;
  logic           w_check;
  logic           w_pass;
  logic           w_fail;
  logic [GAP:0]   w_shift;
  logic [GAP-1:0] w_pend_next;

  // Each endpoint enters at bit 0; the oldest attempt sits in the top bit when due.
  always_comb begin
    w_endpoint = en & r_a_q & b;
    w_check    = en & r_pend[GAP-1];
    w_pass     = w_check & c;
    w_fail     = w_check & ~c;
    w_shift    = {r_pend, w_endpoint};
    if (en) begin
      w_pend_next = w_shift[GAP-1:0];
    end else begin
      w_pend_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_q      <= 1'b0;
      r_pend     <= '0;
      r_endpoint <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_a_q      <= en & a;
      r_pend     <= w_pend_next;
      r_endpoint <= w_endpoint;
      r_pass     <= w_pass;
      r_fail     <= w_fail;
      r_busy     <= |w_pend_next;
    end
  end

  assign endpoint = r_endpoint;
  assign pass     = r_pass;
  assign fail     = r_fail;
  assign busy     = r_busy;

`ifdef SEQ_MON_STATS_EN
  sat_counter #(.WIDTH(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_pass),
    .q   (pass_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_fail),
    .q   (fail_cnt)
  );
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_trigger_monitor.sv
// Randomized bench: three monitors (GAP 1/3/8) on a shared stimulus, checked
// against a due-time reference model.
module tb_seq_trigger_monitor;

  logic clk = 1'b0;
  logic rst, en, a, b, c;

  always #5 clk = ~clk;

  logic        ep1, ps1, fl1, by1;
  logic [15:0] pc1, fc1;
  logic        ep3, ps3, fl3, by3;
  logic [1:0]  pc3, fc3;
  logic        ep8, ps8, fl8, by8;
  logic [3:0]  pc8, fc8;

  seq_trigger_monitor #(.GAP(1), .CNT_W(16)) u_g1 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
    .endpoint(ep1), .pass(ps1), .fail(fl1), .busy(by1),
    .pass_cnt(pc1), .fail_cnt(fc1));

  seq_trigger_monitor #(.GAP(3), .CNT_W(2)) u_g3 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
    .endpoint(ep3), .pass(ps3), .fail(fl3), .busy(by3),
    .pass_cnt(pc3), .fail_cnt(fc3));

  seq_trigger_monitor #(.GAP(8), .CNT_W(4)) u_g8 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
    .endpoint(ep8), .pass(ps8), .fail(fl8), .busy(by8),
    .pass_cnt(pc8), .fail_cnt(fc8));

`ifdef SEQ_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: each attempt is a due edge number in a circular table.
  int gap_m [3];
  int max_m [3];
  bit due_m [3][32];
  bit aq_m  [3];
  bit ep_m  [3];
  bit ps_m  [3];
  bit fl_m  [3];
  bit by_m  [3];
  int pc_m  [3];
  int fc_m  [3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    int slot;
    bit due_now;
    slot = cyc % 32;
    ep_m[i] = 1'b0;
    ps_m[i] = 1'b0;
    fl_m[i] = 1'b0;
    if (rst || !en) begin
      for (int k = 0; k < 32; k++) due_m[i][k] = 1'b0;
      aq_m[i] = 1'b0;
      if (rst) begin
        pc_m[i] = 0;
        fc_m[i] = 0;
      end
    end else begin
      due_now      = due_m[i][slot];
      due_m[i][slot] = 1'b0;
      ps_m[i]      = due_now && c;
      fl_m[i]      = due_now && !c;
      ep_m[i]      = aq_m[i] && b;
      if (ep_m[i]) due_m[i][(cyc + gap_m[i]) % 32] = 1'b1;
      aq_m[i] = a;
      if (STATS && ps_m[i] && pc_m[i] < max_m[i]) pc_m[i]++;
      if (STATS && fl_m[i] && fc_m[i] < max_m[i]) fc_m[i]++;
    end
    by_m[i] = 1'b0;
    for (int k = 0; k < 32; k++) by_m[i] = by_m[i] | due_m[i][k];
  endtask

  task automatic check_inst(input int i, input logic ep, input logic ps, input logic fl,
                            input logic by, input logic [31:0] pc, input logic [31:0] fc);
    string p;
    p = $sformatf("g%0d_", gap_m[i]);
    check_eq({p, "endpoint"}, {31'd0, ep}, {31'd0, ep_m[i]});
    check_eq({p, "pass"},     {31'd0, ps}, {31'd0, ps_m[i]});
    check_eq({p, "fail"},     {31'd0, fl}, {31'd0, fl_m[i]});
    check_eq({p, "excl"},     {31'd0, ps & fl}, 32'd0);
    check_eq({p, "busy"},     {31'd0, by}, {31'd0, by_m[i]});
    check_eq({p, "pass_cnt"}, pc, pc_m[i]);
    check_eq({p, "fail_cnt"}, fc, fc_m[i]);
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic cycle(input logic ia, input logic ib, input logic ic,
                       input logic ien, input logic irst);
    a = ia; b = ib; c = ic; en = ien; rst = irst;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    check_inst(0, ep1, ps1, fl1, by1, {16'd0, pc1}, {16'd0, fc1});
    check_inst(1, ep3, ps3, fl3, by3, {30'd0, pc3}, {30'd0, fc3});
    check_inst(2, ep8, ps8, fl8, by8, {28'd0, pc8}, {28'd0, fc8});
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    gap_m = '{1, 3, 8};
    max_m = '{65535, 3, 15};
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 32; k++) due_m[i][k] = 1'b0;
      aq_m[i] = 1'b0; ep_m[i] = 1'b0; ps_m[i] = 1'b0; fl_m[i] = 1'b0;
      by_m[i] = 1'b0; pc_m[i] = 0; fc_m[i] = 0;
    end

    // Reset with random a/b/c
    for (int k = 0; k < 2; k++)
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);

    // Single passing attempt, then a single failing one
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(9);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(9);

    // Overlapping attempts: a,b,c high for five edges
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Enable dropped two edges after an endpoint: attempt discarded
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Five passing attempts drive small counters into saturation
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);

    // a with no following b: no attempt, no pulse
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);

    // Reset in the middle of pending attempts
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(10);

    // Randomized traffic with occasional enable drops and resets
    for (int k = 0; k < 3000; k++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) != 0),
            1'($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
